// File: rtl/pll_loop_sequencer.sv
// -----------------------------------------------------------------------------
// pll_loop_sequencer
//
// Sequencer for the on-chip digital PLL. After a run request it clears the loop
// filter/NCO, acquires with wide loop gains, declares lock from a run of small
// phase errors and then switches to narrow tracking gains. A run of large phase
// errors while tracking drops back to acquisition (without a loop clear) and
// bumps a saturating relock counter.
//
// Optional feature (compile-time macro PLL_GAIN_STEP_EN):
//   defined   - on entering TRACK the gains ramp from the acquisition values
//               towards the tracking values, +1 every 8 valid samples, each
//               shift saturating independently at its tracking value.
//   undefined - the gains jump to the tracking values on the lock edge.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_enable       run request (level-sensitive)
//   i_err_valid    i_phase_err is valid this cycle
//   i_phase_err    signed two's-complement phase error from the PLL
//   o_loop_clear   clears PLL integrator/NCO while high
//   o_alpha_shift  proportional gain shift to the PLL
//   o_beta_shift   integral gain shift to the PLL
//   o_locked       lock indicator
//   o_lock_lost    one-cycle pulse on loss of lock
//   o_state        0=IDLE 1=CLEAR 2=ACQUIRE 3=TRACK
//   o_relock_cnt   loss-of-lock events, saturating at 255
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module pll_loop_sequencer #(
   parameter int ERR_W           = 8,
   parameter int CLEAR_CYCLES    = 4,
   parameter int LOCK_THRESH     = 8,
   parameter int UNLOCK_THRESH   = 24,
   parameter int LOCK_COUNT      = 16,
   parameter int UNLOCK_COUNT    = 4,
   parameter int ACQ_ALPHA_SHIFT = 2,
   parameter int ACQ_BETA_SHIFT  = 6,
   parameter int TRK_ALPHA_SHIFT = 5,
   parameter int TRK_BETA_SHIFT  = 10
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_err_valid,
   input  logic [ERR_W-1:0] i_phase_err,
   output logic             o_loop_clear,
   output logic [3:0]       o_alpha_shift,
   output logic [3:0]       o_beta_shift,
   output logic             o_locked,
   output logic             o_lock_lost,
   output logic [1:0]       o_state,
   output logic [7:0]       o_relock_cnt
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CLEAR   = 2'd1;
   localparam logic [1:0] ST_ACQUIRE = 2'd2;
   localparam logic [1:0] ST_TRACK   = 2'd3;

   localparam logic [3:0] ACQ_ALPHA = 4'(ACQ_ALPHA_SHIFT);
   localparam logic [3:0] ACQ_BETA  = 4'(ACQ_BETA_SHIFT);
   localparam logic [3:0] TRK_ALPHA = 4'(TRK_ALPHA_SHIFT);
   localparam logic [3:0] TRK_BETA  = 4'(TRK_BETA_SHIFT);

   localparam logic [7:0] CLEAR_LEN  = 8'(CLEAR_CYCLES);
   localparam logic [7:0] LOCK_LEN   = 8'(LOCK_COUNT);
   localparam logic [7:0] UNLOCK_LEN = 8'(UNLOCK_COUNT);

   localparam logic [31:0] LOCK_THR   = 32'(LOCK_THRESH);
   localparam logic [31:0] UNLOCK_THR = 32'(UNLOCK_THRESH);

   localparam logic [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
   localparam logic [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};
   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   logic [1:0] state_reg,      state_next;
   logic [7:0] clear_cnt_reg,  clear_cnt_next;
   logic [7:0] lock_cnt_reg,   lock_cnt_next;
   logic [7:0] miss_cnt_reg,   miss_cnt_next;
   logic [7:0] relock_cnt_reg, relock_cnt_next;
   logic       loop_clear_reg, loop_clear_next;
   logic       locked_reg,     locked_next;
   logic       lock_lost_reg,  lock_lost_next;
   logic [3:0] alpha_reg,      alpha_next;
   logic [3:0] beta_reg,       beta_next;
`ifdef PLL_GAIN_STEP_EN
   // Counts valid samples while tracking; the gains step when it wraps.
   logic [2:0] step_cnt_reg,   step_cnt_next;
`endif

   // ---------------------------------------------------------------------------
   // Phase-error magnitude and sample classification
   // ---------------------------------------------------------------------------
   logic [ERR_W-1:0] abs_err;
   logic [31:0]      abs_ext;
   logic             in_lock;
   logic             out_lock;

   // The most negative code has no positive twin, so it saturates to the
   // largest positive code instead of wrapping back to itself.
   always_comb begin
      abs_err = i_phase_err;
      if (i_phase_err == ERR_MIN) begin
         abs_err = ERR_MAX;
      end else if (i_phase_err[ERR_W-1]) begin
         abs_err = ~i_phase_err + ERR_ONE;
      end
   end

   assign abs_ext  = {{(32-ERR_W){1'b0}}, abs_err};
   assign in_lock  = (abs_ext <= LOCK_THR);
   assign out_lock = (abs_ext > UNLOCK_THR);

   // ---------------------------------------------------------------------------
   // Events shared by the next-state and output logic
   // ---------------------------------------------------------------------------
   logic [7:0] lock_inc;
   logic [7:0] miss_inc;
   logic       clear_done;
   logic       lock_evt;
   logic       loss_evt;

   assign lock_inc   = lock_cnt_reg + 8'd1;
   assign miss_inc   = miss_cnt_reg + 8'd1;
   assign clear_done = (clear_cnt_reg == (CLEAR_LEN - 8'd1));

   // Lock / loss fire on the edge at which the counter would reach its target.
   assign lock_evt = i_enable && (state_reg == ST_ACQUIRE) && i_err_valid
                     && in_lock && (lock_inc == LOCK_LEN);
   assign loss_evt = i_enable && (state_reg == ST_TRACK) && i_err_valid
                     && out_lock && (miss_inc == UNLOCK_LEN);

   // ---------------------------------------------------------------------------
   // Process 1: state and output register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg      <= ST_IDLE;
         clear_cnt_reg  <= 8'd0;
         lock_cnt_reg   <= 8'd0;
         miss_cnt_reg   <= 8'd0;
         relock_cnt_reg <= 8'd0;
         loop_clear_reg <= 1'b0;
         locked_reg     <= 1'b0;
         lock_lost_reg  <= 1'b0;
         alpha_reg      <= ACQ_ALPHA;
         beta_reg       <= ACQ_BETA;
`ifdef PLL_GAIN_STEP_EN
         step_cnt_reg   <= 3'd0;
`endif
      end else begin
         state_reg      <= state_next;
         clear_cnt_reg  <= clear_cnt_next;
         lock_cnt_reg   <= lock_cnt_next;
         miss_cnt_reg   <= miss_cnt_next;
         relock_cnt_reg <= relock_cnt_next;
         loop_clear_reg <= loop_clear_next;
         locked_reg     <= locked_next;
         lock_lost_reg  <= lock_lost_next;
         alpha_reg      <= alpha_next;
         beta_reg       <= beta_next;
`ifdef PLL_GAIN_STEP_EN
         step_cnt_reg   <= step_cnt_next;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Process 2: next state and qualification counters
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      clear_cnt_next = clear_cnt_reg;
      lock_cnt_next  = lock_cnt_reg;
      miss_cnt_next  = miss_cnt_reg;

      if (!i_enable) begin
         // Dropping the run request always wins over threshold activity.
         state_next     = ST_IDLE;
         clear_cnt_next = 8'd0;
         lock_cnt_next  = 8'd0;
         miss_cnt_next  = 8'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next     = ST_CLEAR;
               clear_cnt_next = 8'd0;
               lock_cnt_next  = 8'd0;
               miss_cnt_next  = 8'd0;
            end

            ST_CLEAR: begin
               // Phase errors are meaningless while the loop is being cleared.
               if (clear_done) begin
                  state_next     = ST_ACQUIRE;
                  clear_cnt_next = 8'd0;
               end else begin
                  clear_cnt_next = clear_cnt_reg + 8'd1;
               end
            end

            ST_ACQUIRE: begin
               if (i_err_valid) begin
                  if (lock_evt) begin
                     state_next    = ST_TRACK;
                     lock_cnt_next = 8'd0;
                     miss_cnt_next = 8'd0;
                  end else if (in_lock) begin
                     lock_cnt_next = lock_inc;
                  end else begin
                     lock_cnt_next = 8'd0;
                  end
               end
            end

            ST_TRACK: begin
               if (i_err_valid) begin
                  if (loss_evt) begin
                     // Relock without clearing the loop: it is still close.
                     state_next    = ST_ACQUIRE;
                     miss_cnt_next = 8'd0;
                     lock_cnt_next = 8'd0;
                  end else if (out_lock) begin
                     miss_cnt_next = miss_inc;
                  end else begin
                     miss_cnt_next = 8'd0;
                  end
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Process 3: next values of the registered outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      loop_clear_next = 1'b0;
      lock_lost_next  = 1'b0;
      locked_next     = locked_reg;
      relock_cnt_next = relock_cnt_reg;
      alpha_next      = alpha_reg;
      beta_next       = beta_reg;
`ifdef PLL_GAIN_STEP_EN
      step_cnt_next   = step_cnt_reg;
`endif

      if (!i_enable) begin
         // Relock count is deliberately kept across a disable.
         locked_next = 1'b0;
         alpha_next  = ACQ_ALPHA;
         beta_next   = ACQ_BETA;
`ifdef PLL_GAIN_STEP_EN
         step_cnt_next = 3'd0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               loop_clear_next = 1'b1;
               locked_next     = 1'b0;
               alpha_next      = ACQ_ALPHA;
               beta_next       = ACQ_BETA;
            end

            ST_CLEAR: begin
               loop_clear_next = !clear_done;
            end

            ST_ACQUIRE: begin
               if (lock_evt) begin
                  locked_next = 1'b1;
`ifdef PLL_GAIN_STEP_EN
                  // Gains stay at the acquisition values and ramp from there.
                  step_cnt_next = 3'd0;
`else
                  alpha_next = TRK_ALPHA;
                  beta_next  = TRK_BETA;
`endif
               end
            end

            ST_TRACK: begin
               if (loss_evt) begin
                  locked_next     = 1'b0;
                  lock_lost_next  = 1'b1;
                  relock_cnt_next = (relock_cnt_reg == 8'hFF) ? relock_cnt_reg
                                                              : relock_cnt_reg + 8'd1;
                  alpha_next      = ACQ_ALPHA;
                  beta_next       = ACQ_BETA;
`ifdef PLL_GAIN_STEP_EN
                  step_cnt_next   = 3'd0;
`endif
               end
`ifdef PLL_GAIN_STEP_EN
               else if (i_err_valid) begin
                  step_cnt_next = step_cnt_reg + 3'd1;
                  // Eighth valid sample since the last step: narrow each gain
                  // by one, stopping independently at its tracking value.
                  if (step_cnt_reg == 3'd7) begin
                     if (alpha_reg < TRK_ALPHA) begin
                        alpha_next = alpha_reg + 4'd1;
                     end
                     if (beta_reg < TRK_BETA) begin
                        beta_next = beta_reg + 4'd1;
                     end
                  end
               end
`endif
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_state       = state_reg;
   assign o_loop_clear  = loop_clear_reg;
   assign o_alpha_shift = alpha_reg;
   assign o_beta_shift  = beta_reg;
   assign o_locked      = locked_reg;
   assign o_lock_lost   = lock_lost_reg;
   assign o_relock_cnt  = relock_cnt_reg;

endmodule

// File: tb/tb_pll_loop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_loop_sequencer
//
// Directed bench for pll_loop_sequencer with default parameters. Each step
// drives one cycle of inputs, pushes the expected post-edge outputs onto a
// scoreboard queue, and pops/compares them 1 ns after the clock edge.
// Expected TRACK gains follow the PLL_GAIN_STEP_EN build option.
// -----------------------------------------------------------------------------
module tb_pll_loop_sequencer;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CLEAR   = 2'd1;
   localparam logic [1:0] ST_ACQUIRE = 2'd2;
   localparam logic [1:0] ST_TRACK   = 2'd3;

   typedef struct packed {
      logic [1:0] st;
      logic       clr;
      logic [3:0] alpha;
      logic [3:0] beta;
      logic       locked;
      logic       lost;
      logic [7:0] rc;
   } obs_t;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_enable;
   logic       i_err_valid;
   logic [7:0] i_phase_err;
   logic       o_loop_clear;
   logic [3:0] o_alpha_shift;
   logic [3:0] o_beta_shift;
   logic       o_locked;
   logic       o_lock_lost;
   logic [1:0] o_state;
   logic [7:0] o_relock_cnt;

   int         errors = 0;
   int         checks = 0;
   obs_t       exp_q[$];
   string      tag_q[$];
   logic [7:0] exp_rc = 8'd0;
   logic [1:0] prev_st = ST_IDLE;
   int         trk_n = 0;

   pll_loop_sequencer #(
      .ERR_W(8), .CLEAR_CYCLES(4), .LOCK_THRESH(8), .UNLOCK_THRESH(24),
      .LOCK_COUNT(16), .UNLOCK_COUNT(4), .ACQ_ALPHA_SHIFT(2),
      .ACQ_BETA_SHIFT(6), .TRK_ALPHA_SHIFT(5), .TRK_BETA_SHIFT(10)
   ) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_enable(i_enable),
      .i_err_valid(i_err_valid),
      .i_phase_err(i_phase_err),
      .o_loop_clear(o_loop_clear),
      .o_alpha_shift(o_alpha_shift),
      .o_beta_shift(o_beta_shift),
      .o_locked(o_locked),
      .o_lock_lost(o_lock_lost),
      .o_state(o_state),
      .o_relock_cnt(o_relock_cnt)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Expected gains: acquisition values outside TRACK; inside TRACK either the
   // tracking values, or a ramp of +1 per 8 valid tracking samples.
   function automatic logic [3:0] exp_gain(input logic [1:0] st, input int acq,
                                           input int trk, input int n);
      int g;
      if (st != ST_TRACK) return 4'(acq);
`ifdef PLL_GAIN_STEP_EN
      g = acq + n / 8;
      if (g > trk) g = trk;
      return 4'(g);
`else
      g = trk;
      return 4'(g);
`endif
   endfunction

   task automatic step(input string tag, input bit en, input bit v, input int e,
                       input logic [1:0] st, input bit lost);
      obs_t  ex;
      obs_t  obs;
      string t;
      i_enable    = en;
      i_err_valid = v;
      i_phase_err = 8'(e);
      if (st == ST_TRACK && prev_st == ST_TRACK && v) trk_n++;
      if (st == ST_TRACK && prev_st != ST_TRACK) trk_n = 0;
      ex.st     = st;
      ex.clr    = (st == ST_CLEAR);
      ex.alpha  = exp_gain(st, 2, 5, trk_n);
      ex.beta   = exp_gain(st, 6, 10, trk_n);
      ex.locked = (st == ST_TRACK);
      ex.lost   = lost;
      ex.rc     = exp_rc;
      exp_q.push_back(ex);
      tag_q.push_back(tag);
      prev_st = st;

      @(posedge i_clk);
      #1;
      obs.st     = o_state;
      obs.clr    = o_loop_clear;
      obs.alpha  = o_alpha_shift;
      obs.beta   = o_beta_shift;
      obs.locked = o_locked;
      obs.lost   = o_lock_lost;
      obs.rc     = o_relock_cnt;
      ex = exp_q.pop_front();
      t  = tag_q.pop_front();
      checks++;
      assert (obs === ex) else begin
         errors++;
         $error("FAIL %s: got st=%0d clr=%0d a=%0d b=%0d lk=%0d lost=%0d rc=%0d, expected st=%0d clr=%0d a=%0d b=%0d lk=%0d lost=%0d rc=%0d",
                t, obs.st, obs.clr, obs.alpha, obs.beta, obs.locked, obs.lost, obs.rc,
                ex.st, ex.clr, ex.alpha, ex.beta, ex.locked, ex.lost, ex.rc);
      end
      $display("step %-12s en=%0d v=%0d err=%4d -> st=%0d clr=%0d a=%0d b=%0d lk=%0d lost=%0d rc=%0d",
               t, en, v, $signed(8'(e)), obs.st, obs.clr, obs.alpha, obs.beta,
               obs.locked, obs.lost, obs.rc);
   endtask

   initial begin
      i_reset = 1'b1; i_enable = 1'b0; i_err_valid = 1'b0; i_phase_err = 8'd0;

      // Reset state
      step("reset", 0, 0, 0, ST_IDLE, 0);
      step("reset", 0, 0, 0, ST_IDLE, 0);
      i_reset = 1'b0;
      step("idle", 0, 1, 0, ST_IDLE, 0);

      // Enable: exactly 4 clear cycles; good samples during clear are ignored
      for (int i = 0; i < 4; i++) step("clear", 1, 1, 0, ST_CLEAR, 0);
      step("clear_exit", 1, 1, 0, ST_ACQUIRE, 0);

      // Partial acquisition, then disable: lock progress must be discarded
      for (int i = 0; i < 10; i++) step("acq_pre", 1, 1, 5, ST_ACQUIRE, 0);
      step("disable", 0, 1, 5, ST_IDLE, 0);
      for (int i = 0; i < 4; i++) step("clear2", 1, 0, 0, ST_CLEAR, 0);
      step("clear2_exit", 1, 0, 0, ST_ACQUIRE, 0);

      // 16 samples of +5 -> lock on the 16th
      for (int i = 1; i <= 16; i++)
         step("acq_p5", 1, 1, 5, (i == 16) ? ST_TRACK : ST_ACQUIRE, 0);

      // Loss: 3x30, 0 (clears miss), 4x-25 -> lost on 4th
      for (int i = 0; i < 3; i++) step("trk_30", 1, 1, 30, ST_TRACK, 0);
      step("trk_0", 1, 1, 0, ST_TRACK, 0);
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) exp_rc = 8'd1;
         step("trk_m25", 1, 1, -25, (i == 4) ? ST_ACQUIRE : ST_TRACK, (i == 4));
      end

      // Reacquire with +-8 (boundary, in-lock) and -128 at sample 10 -> 26 total
      for (int i = 1; i <= 26; i++)
         step("acq_restart", 1, 1, (i == 10) ? -128 : ((i % 2) ? 8 : -8),
              (i == 26) ? ST_TRACK : ST_ACQUIRE, 0);

      // Long good stretch in TRACK with invalid garbage interleaved
      for (int i = 0; i < 48; i++) begin
         if (i % 6 == 5) step("trk_inval", 1, 0, 127, ST_TRACK, 0);
         else            step("trk_good", 1, 1, 0, ST_TRACK, 0);
      end

      // Unlock boundary: 24 is not a miss and clears the run
      for (int i = 0; i < 3; i++) step("trk_25", 1, 1, 25, ST_TRACK, 0);
      step("trk_24", 1, 1, 24, ST_TRACK, 0);
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) exp_rc = 8'd2;
         step("trk_25b", 1, 1, 25, (i == 4) ? ST_ACQUIRE : ST_TRACK, (i == 4));
      end

      // Acquisition with invalid garbage between good samples
      for (int i = 0; i < 16; i++) begin
         step("acq_inval", 1, 0, 127, ST_ACQUIRE, 0);
         step("acq_good", 1, 1, 3, (i == 15) ? ST_TRACK : ST_ACQUIRE, 0);
      end

      // Invalid cycle holds the miss count
      step("trk_m30", 1, 1, -30, ST_TRACK, 0);
      step("trk_m30", 1, 1, -30, ST_TRACK, 0);
      step("trk_hold", 1, 0, 0, ST_TRACK, 0);
      step("trk_m30", 1, 1, -30, ST_TRACK, 0);
      exp_rc = 8'd3;
      step("trk_m30", 1, 1, -30, ST_ACQUIRE, 1);

      // Relock, then drop enable in TRACK
      for (int i = 1; i <= 16; i++)
         step("acq_m3", 1, 1, -3, (i == 16) ? ST_TRACK : ST_ACQUIRE, 0);
      step("trk_disable", 0, 1, 127, ST_IDLE, 0);
      step("idle_hold", 0, 0, 0, ST_IDLE, 0);

      // Reset beats enable and clears the relock count
      i_reset = 1'b1;
      exp_rc  = 8'd0;
      step("mid_reset", 1, 0, 0, ST_IDLE, 0);
      i_reset = 1'b0;
      step("post_reset", 1, 0, 0, ST_CLEAR, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
